// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - EX/MEM consumer: data-memory req/ack access and MEM/WB register
// Optional bus watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module memory_stage #(
  parameter int DATA_WIDTH        = 32,
  parameter int DMEM_ADDR_WIDTH   = 20,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_in,
  input  logic                         mem_data_rd_en_in,
  input  logic                         mem_data_wr_en_in,
  input  logic [DATA_WIDTH-1:0]        mem_data_in,
  input  logic [DATA_WIDTH-1:0]        alu_data_in,
  input  logic                         reg_wr_en_in,
  input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_in,
  input  logic                         write_back_mux_sel_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  output logic                         stall_out,
  output logic                         dmem_req_out,
  output logic                         dmem_we_out,
  output logic [DMEM_ADDR_WIDTH-1:0]   dmem_addr_out,
  output logic [DATA_WIDTH-1:0]        dmem_wdata_out,
  input  logic [DATA_WIDTH-1:0]        dmem_rdata_in,
  input  logic                         dmem_ack_in,
  output logic                         reg_wr_en_out,
  output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
  output logic [DATA_WIDTH-1:0]        write_back_data_out,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic                         bus_error_out
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                         state;
  logic                           mem_op;
  logic                           timeout_hit;
  logic [DATA_WIDTH-1:0]          lat_alu;
  logic                           lat_reg_wr_en;
  logic [REG_ADDR_WIDTH-1:0]      lat_reg_wr_addr;
  logic                           lat_load_data;
  logic [INSTRUCTION_WIDTH-1:0]   lat_instr;

  // A flushed instruction never starts a bus access; write wins when both enables are set
  assign mem_op = (mem_data_rd_en_in | mem_data_wr_en_in) & ~flush_in;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] access_cnt;
  logic             bus_error_q;

  // Watchdog fires on the last allowed ACCESS cycle when no ack has arrived
  assign timeout_hit   = (state == ACCESS) && !dmem_ack_in &&
                         (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_error_out = bus_error_q;
`else
  assign timeout_hit   = 1'b0;
  assign bus_error_out = 1'b0;
`endif

  // Hold upstream while a new access is being launched or one is still outstanding
  assign stall_out = ((state == IDLE) && mem_op) ||
                     ((state == ACCESS) && !dmem_ack_in && !timeout_hit);

  // Bus sequencing and MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      dmem_req_out        <= 1'b0;
      dmem_we_out         <= 1'b0;
      dmem_addr_out       <= '0;
      dmem_wdata_out      <= '0;
      reg_wr_en_out       <= 1'b0;
      reg_wr_addr_out     <= '0;
      write_back_data_out <= '0;
      instruction_out     <= '0;
      lat_alu             <= '0;
      lat_reg_wr_en       <= 1'b0;
      lat_reg_wr_addr     <= '0;
      lat_load_data       <= 1'b0;
      lat_instr           <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      access_cnt          <= '0;
      bus_error_q         <= 1'b0;
`endif
    end else begin
      // MEM/WB defaults to a bubble; branches below overwrite it when a result retires
      reg_wr_en_out       <= 1'b0;
      reg_wr_addr_out     <= '0;
      write_back_data_out <= '0;
      instruction_out     <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      bus_error_q         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_req_out    <= 1'b1;
            dmem_we_out     <= mem_data_wr_en_in;
            dmem_addr_out   <= alu_data_in[DMEM_ADDR_WIDTH-1:0];
            dmem_wdata_out  <= mem_data_in;
            lat_alu         <= alu_data_in;
            lat_reg_wr_en   <= reg_wr_en_in;
            lat_reg_wr_addr <= reg_wr_addr_in;
            lat_load_data   <= write_back_mux_sel_in & ~mem_data_wr_en_in;
            lat_instr       <= instruction_in;
            state           <= ACCESS;
`ifdef MEM_ACCESS_TIMEOUT_EN
            access_cnt      <= '0;
`endif
          end else if (!flush_in) begin
            reg_wr_en_out       <= reg_wr_en_in;
            reg_wr_addr_out     <= reg_wr_addr_in;
            write_back_data_out <= alu_data_in;
            instruction_out     <= instruction_in;
          end
        end
        ACCESS: begin
          if (dmem_ack_in) begin
            dmem_req_out        <= 1'b0;
            dmem_we_out         <= 1'b0;
            state               <= IDLE;
            reg_wr_en_out       <= lat_reg_wr_en;
            reg_wr_addr_out     <= lat_reg_wr_addr;
            write_back_data_out <= lat_load_data ? dmem_rdata_in : lat_alu;
            instruction_out     <= lat_instr;
          end else if (timeout_hit) begin
            dmem_req_out        <= 1'b0;
            dmem_we_out         <= 1'b0;
            state               <= IDLE;
            reg_wr_addr_out     <= lat_reg_wr_addr;
            instruction_out     <= lat_instr;
`ifdef MEM_ACCESS_TIMEOUT_EN
            bus_error_q         <= 1'b1;
`endif
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          access_cnt <= access_cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard testbench for memory_stage
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_in = 1'b0;
  logic        mem_data_rd_en_in = 1'b0;
  logic        mem_data_wr_en_in = 1'b0;
  logic [31:0] mem_data_in = '0;
  logic [31:0] alu_data_in = '0;
  logic        reg_wr_en_in = 1'b0;
  logic [4:0]  reg_wr_addr_in = '0;
  logic        write_back_mux_sel_in = 1'b0;
  logic [31:0] instruction_in = '0;
  logic        stall_out;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [19:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [31:0] dmem_rdata_in = 32'hBAD0BAD0;
  logic        dmem_ack_in = 1'b0;
  logic        reg_wr_en_out;
  logic [4:0]  reg_wr_addr_out;
  logic [31:0] write_back_data_out;
  logic [31:0] instruction_out;
  logic        bus_error_out;

  memory_stage dut (
    .clk(clk), .rst(rst), .flush_in(flush_in),
    .mem_data_rd_en_in(mem_data_rd_en_in), .mem_data_wr_en_in(mem_data_wr_en_in),
    .mem_data_in(mem_data_in), .alu_data_in(alu_data_in),
    .reg_wr_en_in(reg_wr_en_in), .reg_wr_addr_in(reg_wr_addr_in),
    .write_back_mux_sel_in(write_back_mux_sel_in), .instruction_in(instruction_in),
    .stall_out(stall_out), .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
    .dmem_rdata_in(dmem_rdata_in), .dmem_ack_in(dmem_ack_in),
    .reg_wr_en_out(reg_wr_en_out), .reg_wr_addr_out(reg_wr_addr_out),
    .write_back_data_out(write_back_data_out), .instruction_out(instruction_out),
    .bus_error_out(bus_error_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rwe;
    logic [4:0]  ra;
    logic [31:0] data;
    logic [31:0] ins;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every non-bubble MEM/WB output retires the oldest expected result
  always @(negedge clk) begin
    if (!rst && instruction_out != 32'h0) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", instruction_out, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_instr", instruction_out, e.ins);
        chk("wb_reg_wr_en", {31'h0, reg_wr_en_out}, {31'h0, e.rwe});
        chk("wb_reg_addr", {27'h0, reg_wr_addr_out}, {27'h0, e.ra});
        chk("wb_data", write_back_data_out, e.data);
        chk("wb_latency_cycle", cyc, e.due);
      end
    end
  end

  task automatic go_idle();
    mem_data_rd_en_in = 1'b0; mem_data_wr_en_in = 1'b0; flush_in = 1'b0;
    reg_wr_en_in = 1'b0; reg_wr_addr_in = '0; write_back_mux_sel_in = 1'b0;
    instruction_in = '0; alu_data_in = '0; mem_data_in = '0;
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic rwe, input logic [4:0] ra,
                        input logic [31:0] ins);
    exp_t e;
    alu_data_in = alu; reg_wr_en_in = rwe; reg_wr_addr_in = ra; instruction_in = ins;
    mem_data_rd_en_in = 1'b0; mem_data_wr_en_in = 1'b0; flush_in = 1'b0;
    e.rwe = rwe; e.ra = ra; e.data = alu; e.ins = ins; e.due = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    chk("alu_stall", {31'h0, stall_out}, 32'h0);
    chk("alu_no_req", {31'h0, dmem_req_out}, 32'h0);
    @(posedge clk); #1;
    go_idle();
  endtask

  // Memory op acked n cycles after the first ACCESS cycle
  task automatic mem_op(input logic rd, input logic wr, input logic [31:0] alu,
                        input logic [31:0] wd, input logic rwe, input logic [4:0] ra,
                        input logic sel, input logic [31:0] ins, input int n,
                        input logic [31:0] rdv, input logic fl_mid);
    exp_t e;
    mem_data_rd_en_in = rd; mem_data_wr_en_in = wr; alu_data_in = alu; mem_data_in = wd;
    reg_wr_en_in = rwe; reg_wr_addr_in = ra; write_back_mux_sel_in = sel;
    instruction_in = ins; flush_in = 1'b0;
    e.rwe = rwe; e.ra = ra; e.data = (!wr && sel) ? rdv : alu; e.ins = ins;
    e.due = cyc + 2 + n;
    sb.push_back(e);
    @(negedge clk);
    chk("launch_stall", {31'h0, stall_out}, 32'h1);
    chk("launch_req_low", {31'h0, dmem_req_out}, 32'h0);
    @(posedge clk); #1;
    flush_in = fl_mid;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("wait_req", {31'h0, dmem_req_out}, 32'h1);
      chk("wait_stall", {31'h0, stall_out}, 32'h1);
      chk("wait_addr", {12'h0, dmem_addr_out}, {12'h0, alu[19:0]});
      chk("wait_bubble", instruction_out, 32'h0);
      @(posedge clk); #1;
    end
    dmem_ack_in = 1'b1; dmem_rdata_in = rdv;
    @(negedge clk);
    chk("ack_req", {31'h0, dmem_req_out}, 32'h1);
    chk("ack_we", {31'h0, dmem_we_out}, {31'h0, wr});
    chk("ack_addr", {12'h0, dmem_addr_out}, {12'h0, alu[19:0]});
    if (wr) chk("ack_wdata", dmem_wdata_out, wd);
    chk("ack_stall", {31'h0, stall_out}, 32'h0);
    @(posedge clk); #1;
    dmem_ack_in = 1'b0; dmem_rdata_in = 32'hBAD0BAD0;
    go_idle();
  endtask

  initial begin
    go_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'h0, dmem_req_out}, 32'h0);
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_wb", write_back_data_out, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_addr", {12'h0, dmem_addr_out}, 32'h0);
    chk("rst_bus_error", {31'h0, bus_error_out}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    alu_op(32'h1234, 1'b1, 5'd3, 32'h11);
    // load, ack in third ACCESS cycle
    mem_op(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 5'd5, 1'b1, 32'h22, 2, 32'hDEADBEEF, 1'b0);
    // store, ack in first ACCESS cycle
    mem_op(1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 32'h33, 0, 32'h0, 1'b0);
    // back-to-back load then store (both enables high: treated as write)
    mem_op(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 5'd7, 1'b1, 32'h44, 1, 32'h0BADF00D, 1'b0);
    mem_op(1'b1, 1'b1, 32'h84, 32'h12345678, 1'b0, 5'd2, 1'b1, 32'h55, 0, 32'hFFFFFFFF, 1'b0);
    // load writing back ALU value
    mem_op(1'b1, 1'b0, 32'h99, 32'h0, 1'b1, 5'd9, 1'b0, 32'h66, 1, 32'hCAFE, 1'b0);

    // flush in IDLE squashes the load
    mem_data_rd_en_in = 1'b1; flush_in = 1'b1; reg_wr_en_in = 1'b1;
    reg_wr_addr_in = 5'd4; instruction_in = 32'h77; alu_data_in = 32'h50;
    @(negedge clk);
    chk("flush_stall", {31'h0, stall_out}, 32'h0);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    chk("flush_no_req", {31'h0, dmem_req_out}, 32'h0);
    chk("flush_bubble_we", {31'h0, reg_wr_en_out}, 32'h0);
    chk("flush_bubble_instr", instruction_out, 32'h0);
    @(posedge clk); #1;

    // flush during ACCESS does not cancel
    mem_op(1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 5'd12, 1'b1, 32'h88, 2, 32'h13572468, 1'b1);
    alu_op(32'h7777, 1'b1, 5'd1, 32'h99);

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      exp_t e;
      mem_data_rd_en_in = 1'b1; reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd6;
      write_back_mux_sel_in = 1'b1; instruction_in = 32'hBB; alu_data_in = 32'h70;
      e.rwe = 1'b0; e.ra = 5'd6; e.data = 32'h0; e.ins = 32'hBB; e.due = cyc + 17;
      sb.push_back(e);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        chk("to_req", {31'h0, dmem_req_out}, 32'h1);
        chk("to_stall", {31'h0, stall_out}, (i == 15) ? 32'h0 : 32'h1);
        @(posedge clk); #1;
      end
      go_idle();
      @(negedge clk);
      chk("to_req_drop", {31'h0, dmem_req_out}, 32'h0);
      chk("to_bus_error", {31'h0, bus_error_out}, 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_bus_error_pulse", {31'h0, bus_error_out}, 32'h0);
      @(posedge clk); #1;
    end
`endif

    // reset mid-access, then a late ack in IDLE
    mem_data_rd_en_in = 1'b1; reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd8;
    instruction_in = 32'hAA; alu_data_in = 32'h123;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    chk("midrst_req", {31'h0, dmem_req_out}, 32'h0);
    chk("midrst_addr", {12'h0, dmem_addr_out}, 32'h0);
    chk("midrst_instr", instruction_out, 32'h0);
    chk("midrst_stall", {31'h0, stall_out}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack_in = 1'b1; dmem_rdata_in = 32'h55AA55AA;
    @(negedge clk);
    chk("late_ack_stall", {31'h0, stall_out}, 32'h0);
    @(posedge clk); #1;
    dmem_ack_in = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'h0, dmem_req_out}, 32'h0);
    chk("late_ack_instr", instruction_out, 32'h0);
    chk("end_bus_error", {31'h0, bus_error_out}, 32'h0);
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
